// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK bank driver.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, per-bit {J,K} excitation codes, popcount helper.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Per-bit excitation codes, packed as {J,K}.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Number of set bits in a word of up to 32 bits (callers zero-extend).
  function automatic logic [7:0] popcount(input logic [31:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// Target word queue: circular buffer with wrap-bit pointers.
// Latency: a pushed word is visible at head_dat the cycle after the push edge.
// Backpressure: full stays high on a simultaneous pop; no push-through.
// Ports: clk, rst_n (async, active low); push_vld/push_dat write side;
//        pop read side; full, empty, head_dat status/head word.
module jk_tgt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             push_ok;
  logic             pop_ok;

  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty    = (wptr_q == rptr_q);
  assign head_dat = mem_q[rptr_q[AW-1:0]];

  assign push_ok = push_vld && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d = rptr_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: the pointers define which slots hold live data.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Steers an external JK flop bank to queued target words, verifies Q, retries.
// Latency: done 3 cycles after acceptance on an idle driver; one word per 3 cycles.
// Backpressure: tgt_ready = !fifo_full; words stall while the queue is full.
// Ports: clk, rst_n; tgt_valid/tgt_data/tgt_ready target input; mode (latched at pop);
//        q_in bank readback; j/k registered excitation; busy, done, err, flips status.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       flips
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_tgt_q, cur_tgt_d;
  logic             cur_mode_q, cur_mode_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [RW-1:0]    retry_cnt_q, retry_cnt_d;
  logic [7:0]       flips_acc_q, flips_acc_d;
  logic [7:0]       flips_q, flips_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head_tgt;
  logic             fifo_pop;
  logic [31:0]      diff32;
  logic [8:0]       acc_sum;

  jk_tgt_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (tgt_valid && tgt_ready),
    .push_dat (tgt_data),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_tgt)
  );

  // {J,K} word that moves each differing bit toward tgt; equal bits hold.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] tgt,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic             tgl);
    logic [WIDTH-1:0] jv;
    logic [WIDTH-1:0] kv;
    logic [1:0]       code;
    for (int i = 0; i < WIDTH; i++) begin
      if (tgt[i] == q[i])  code = JK_HOLD;
      else if (tgl)        code = JK_TGL;
      else if (tgt[i])     code = JK_SET;
      else                 code = JK_RST;
      jv[i] = code[1];
      kv[i] = code[0];
    end
    return {jv, kv};
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_tgt_d   = cur_tgt_q;
    cur_mode_d  = cur_mode_q;
    retry_cnt_d = retry_cnt_q;
    flips_acc_d = flips_acc_q;
    flips_d     = flips_q;
    j_d         = '0;
    k_d         = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fifo_pop    = 1'b0;
    diff32      = '0;
    acc_sum     = '0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop           = 1'b1;
          cur_tgt_d          = head_tgt;
          cur_mode_d         = mode;
          {j_d, k_d}         = excite(head_tgt, q_in, mode);
          retry_cnt_d        = '0;
          diff32[WIDTH-1:0]  = head_tgt ^ q_in;
          flips_acc_d        = popcount(diff32);
          state_d            = DRIVE;
        end
      end

      // The bank samples j/k at the edge leaving DRIVE; they drop to 0 afterwards.
      DRIVE: begin
        state_d = SETTLE;
      end

      SETTLE: begin
        if (q_in == cur_tgt_q) begin
          done_d  = 1'b1;
          flips_d = flips_acc_q;
          state_d = IDLE;
        end else if (retry_cnt_q < RETRY_MAX) begin
          retry_cnt_d       = retry_cnt_q + RW'(1);
          {j_d, k_d}        = excite(cur_tgt_q, q_in, cur_mode_q);
          diff32[WIDTH-1:0] = cur_tgt_q ^ q_in;
          acc_sum           = {1'b0, flips_acc_q} + {1'b0, popcount(diff32)};
          flips_acc_d       = acc_sum[8] ? 8'hFF : acc_sum[7:0];
          state_d           = DRIVE;
        end else begin
          err_d   = 1'b1;
          flips_d = flips_acc_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_tgt_q   <= '0;
      cur_mode_q  <= 1'b0;
      j_q         <= '0;
      k_q         <= '0;
      retry_cnt_q <= '0;
      flips_acc_q <= '0;
      flips_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_tgt_q   <= cur_tgt_d;
      cur_mode_q  <= cur_mode_d;
      j_q         <= j_d;
      k_q         <= k_d;
      retry_cnt_q <= retry_cnt_d;
      flips_acc_q <= flips_acc_d;
      flips_q     <= flips_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign tgt_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign flips     = flips_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: JK bank model with stuck-bit fault, scenario tasks.
// Latency: n/a.
// Backpressure: n/a.
module tb_jk_bank_driver;

  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tgt_valid = 1'b0;
  logic [3:0] tgt_data = '0;
  logic       mode = 1'b0;
  logic       tgt_ready, busy, done, err;
  logic [3:0] q_in, j, k;
  logic [7:0] flips;

  logic [3:0] q_bank = '0;
  logic [3:0] stuck_mask = '0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  // Completion log filled by the monitor at each falling edge.
  int         done_cnt = 0, err_cnt = 0, drive_cnt = 0, both_cnt = 0;
  int         done_cyc[$];
  logic [3:0] done_q[$];
  logic [7:0] done_fl[$];
  logic [7:0] err_fl[$];

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(4), .FIFO_DEPTH(4), .MAX_RETRY(MAXR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .mode      (mode),
    .q_in      (q_in),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .flips     (flips)
  );

  // External JK bank: characteristic equation Q+ = J&~Q | ~K&Q, stuck bits held at 0.
  assign q_in = q_bank;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    q_bank <= ((j & ~q_bank) | (~k & q_bank)) & ~stuck_mask;
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      done_q.push_back(q_in);
      done_fl.push_back(flips);
    end
    if (err) begin
      err_cnt++;
      err_fl.push_back(flips);
    end
    if (done && err) both_cnt++;
    if ((j | k) != 4'b0) drive_cnt++;
  end

  // Outcome of one target: the bank lands on tgt except for stuck bits; every
  // attempt adds the number of differing bits; MAXR retries after the first.
  task automatic model_op(input logic [3:0] t, input logic [3:0] q0, input logic [3:0] mask,
                          output bit ok, output int fl, output int drives);
    logic [3:0] q;
    q = q0; ok = 0; fl = 0; drives = 0;
    for (int a = 0; a <= MAXR; a++) begin
      fl += $countones(t ^ q);
      if (t != q) drives++;
      q = t & ~mask;
      if (q == t) begin
        ok = 1;
        break;
      end
    end
    if (fl > 255) fl = 255;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d, input logic m, output int acc_cyc, output int stalls);
    stalls = 0;
    acc_cyc = -1;
    step();
    tgt_valid = 1'b1;
    tgt_data  = d;
    mode      = m;
    while (!tgt_ready && stalls < 40) begin
      step();
      stalls++;
    end
    if (!tgt_ready) begin
      n_chk++; n_fail++;
      $display("FAIL push_timeout: tgt_ready stayed 0 for %0d cycles, required 1", stalls);
      tgt_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      tgt_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      step();
      n++;
    end
    if (busy) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_chk++;
    if ({j, k, done, err, flips} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: j=%b k=%b done=%b err=%b flips=%0d, required all 0", j, k, done, err, flips);
    end
    n_chk++;
    if ({tgt_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_status: tgt_ready=%b busy=%b, required 1 0", tgt_ready, busy);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_set_reset();
    int ac, st;
    push(4'b1010, 1'b0, ac, st);
    step();
    n_chk++;
    if ({busy, j, k} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL t1_queued: busy=%b j=%b k=%b, required 1 0000 0000", busy, j, k);
    end
    step();
    n_chk++;
    if ({j, k} !== {4'b1010, 4'b0000}) begin
      n_fail++;
      $display("FAIL t1_drive: j=%b k=%b, required 1010 0000", j, k);
    end
    step();
    n_chk++;
    if ({j, k, q_in, done} !== {8'h00, 4'b1010, 1'b0}) begin
      n_fail++;
      $display("FAIL t1_settle: j=%b k=%b q=%b done=%b, required 0000 0000 1010 0", j, k, q_in, done);
    end
    step();
    n_chk++;
    if ({done, err, flips} !== {1'b1, 1'b0, 8'd2} || done_cyc[$] - ac != 3) begin
      n_fail++;
      $display("FAIL t1_done: done=%b err=%b flips=%0d lat=%0d, required 1 0 2 lat 3",
               done, err, flips, done_cyc[$] - ac);
    end
    step();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_toggle();
    int ac, st;
    push(4'b0101, 1'b1, ac, st);
    step();
    step();
    n_chk++;
    if ({j, k} !== 8'hFF) begin
      n_fail++;
      $display("FAIL t2_drive: j=%b k=%b, required 1111 1111", j, k);
    end
    step();
    n_chk++;
    if ({j, k, q_in} !== {8'h00, 4'b0101}) begin
      n_fail++;
      $display("FAIL t2_settle: j=%b k=%b q=%b, required 0000 0000 0101", j, k, q_in);
    end
    step();
    n_chk++;
    if ({done, flips} !== {1'b1, 8'd4}) begin
      n_fail++;
      $display("FAIL t2_done: done=%b flips=%0d, required 1 4", done, flips);
    end
    wait_idle(20);
  endtask

  task automatic test_back_to_back();
    logic [3:0] w[7];
    int         ac[7], st[7], exp_fl[7];
    int         base, drv, sum_early;
    bit         ok;
    logic [3:0] prev;
    prev = q_in;
    for (int i = 0; i < 7; i++) begin
      w[i] = 4'($urandom_range(0, 15));
      model_op(w[i], prev, 4'b0000, ok, exp_fl[i], drv);
      prev = w[i];
    end
    base = done_cnt;
    for (int i = 0; i < 7; i++) push(w[i], 1'($urandom_range(0, 1)), ac[i], st[i]);
    sum_early = 0;
    for (int i = 0; i < 6; i++) sum_early += st[i];
    n_chk++;
    if (sum_early != 0 || st[6] != 2) begin
      n_fail++;
      $display("FAIL t3_stall: first six stalled %0d, seventh stalled %0d, required 0 and 2", sum_early, st[6]);
    end
    wait_idle(100);
    n_chk++;
    if (done_cnt - base != 7) begin
      n_fail++;
      $display("FAIL t3_count: %0d done pulses, required 7", done_cnt - base);
    end else begin
      n_chk++;
      if (done_cyc[base] - ac[0] != 3) begin
        n_fail++;
        $display("FAIL t3_first_lat: latency %0d, required 3", done_cyc[base] - ac[0]);
      end
      for (int i = 0; i < 7; i++) begin
        n_chk++;
        if (done_q[base+i] !== w[i] || done_fl[base+i] !== 8'(exp_fl[i])) begin
          n_fail++;
          $display("FAIL t3_word%0d: q=%b flips=%0d, required q=%b flips=%0d",
                   i, done_q[base+i], done_fl[base+i], w[i], exp_fl[i]);
        end
        if (i > 0) begin
          n_chk++;
          if (done_cyc[base+i] - done_cyc[base+i-1] != 3) begin
            n_fail++;
            $display("FAIL t3_gap%0d: spacing %0d cycles, required 3", i,
                     done_cyc[base+i] - done_cyc[base+i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_stuck_retry();
    int  ac, st, d0, e0, dr0, exp_fl, exp_drv;
    bit  ok;
    push(4'b0000, 1'b0, ac, st);
    wait_idle(20);
    stuck_mask = 4'b0001;
    model_op(4'b0001, q_in, stuck_mask, ok, exp_fl, exp_drv);
    d0 = done_cnt; e0 = err_cnt; dr0 = drive_cnt;
    push(4'b0001, 1'b0, ac, st);
    wait_idle(40);
    n_chk++;
    if (drive_cnt - dr0 != exp_drv) begin
      n_fail++;
      $display("FAIL t4_drives: %0d drive cycles, required %0d", drive_cnt - dr0, exp_drv);
    end
    n_chk++;
    if (err_cnt - e0 != (ok ? 0 : 1) || done_cnt - d0 != (ok ? 1 : 0)) begin
      n_fail++;
      $display("FAIL t4_outcome: err pulses %0d done pulses %0d, required %0d %0d",
               err_cnt - e0, done_cnt - d0, ok ? 0 : 1, ok ? 1 : 0);
    end
    n_chk++;
    if (err_fl.size() == 0 || err_fl[$] !== 8'(exp_fl)) begin
      n_fail++;
      $display("FAIL t4_flips: err flips %0d, required %0d", err_fl.size() ? err_fl[$] : 8'hxx, exp_fl);
    end
    stuck_mask = 4'b0000;
  endtask

  task automatic test_equal_target();
    int ac, st, d0, dr0;
    d0 = done_cnt; dr0 = drive_cnt;
    push(q_in, 1'($urandom_range(0, 1)), ac, st);
    wait_idle(20);
    n_chk++;
    if (drive_cnt - dr0 != 0 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL t5_equal: drive cycles %0d done pulses %0d, required 0 1", drive_cnt - dr0, done_cnt - d0);
    end
    n_chk++;
    if (done_fl[$] !== 8'd0 || done_cyc[$] - ac != 3) begin
      n_fail++;
      $display("FAIL t5_flips_lat: flips=%0d lat=%0d, required 0 3", done_fl[$], done_cyc[$] - ac);
    end
  endtask

  task automatic test_reset_mid_drive();
    int         ac, st, d0, e0;
    logic [3:0] w1;
    w1 = 4'($urandom_range(0, 15));
    push(w1, 1'b0, ac, st);
    push(~w1, 1'b0, ac, st);
    push(4'($urandom_range(0, 15)), 1'b0, ac, st);
    push(4'($urandom_range(0, 15)), 1'b0, ac, st);
    step();
    step();
    n_chk++;
    if ((j | k) === 4'b0000) begin
      n_fail++;
      $display("FAIL t6_in_drive: j=%b k=%b before reset, required nonzero", j, k);
    end
    d0 = done_cnt; e0 = err_cnt;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({j, k, tgt_ready, busy, done, err} !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL t6_async: j=%b k=%b rdy=%b busy=%b done=%b err=%b, required 0000 0000 1 0 0 0",
               j, k, tgt_ready, busy, done, err);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    n_chk++;
    if (done_cnt != d0 || err_cnt != e0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_after: done pulses %0d err pulses %0d busy=%b, required 0 0 0",
               done_cnt - d0, err_cnt - e0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_toggle();
    test_back_to_back();
    test_stuck_retry();
    test_equal_target();
    test_back_to_back();
    test_reset_mid_drive();
    n_chk++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL done_err_exclusive: %0d cycles with both high, required 0", both_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
